// File: rtl/seg_pkg.sv
// Shared definitions for the segment-display source arbiter.
//   SRC_N / SRC_W : number of sources and width of a source index
//   DATA_W        : width of one source word
//   state_e       : arbiter state (IDLE = nothing granted, SHOW = a source is granted)
//   ms_ticks()    : clock cycles per millisecond for a given clock frequency
package seg_pkg;

   localparam int unsigned SRC_N  = 4;
   localparam int unsigned SRC_W  = 2;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [0:0] {
      IDLE,
      SHOW
   } state_e;

   function automatic int unsigned ms_ticks(input int unsigned clk_freq);
      return clk_freq / 1000;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clear : restart the millisecond period (counter back to 0)
//   tick  : high for one cycle every CLK_FREQ/1000 cycles
module ms_tick_gen
   import seg_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned TICKS = ms_ticks(CLK_FREQ);
   localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_source_arbiter.sv
// Picks one of four sources for a 32-bit segment display: round-robin with a minimum
// dwell time per source, optional pinning, and immediate re-grant when the shown
// source goes away.
//   clk, rst_n   : clock, asynchronous active-low reset
//   src_valid    : per-source display request
//   src_data     : source i word on bits [32*i+31:32*i]
//   pin_en/sel   : force display of source pin_sel while it is valid
//   disp_data    : registered word of the granted source (0 when blank)
//   disp_src     : granted source index (held while blank)
//   disp_blank   : nothing granted
//   switch_pulse : one-cycle pulse on every new grant
module seg_source_arbiter
   import seg_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned DWELL_MS = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SRC_N-1:0]        src_valid,
   input  logic [SRC_N*DATA_W-1:0] src_data,
   input  logic                    pin_en,
   input  logic [SRC_W-1:0]        pin_sel,
   output logic [DATA_W-1:0]       disp_data,
   output logic [SRC_W-1:0]        disp_src,
   output logic                    disp_blank,
   output logic                    switch_pulse
);

   localparam int unsigned DW_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_MS - 1);

   state_e            state_q, state_d;
   logic [SRC_W-1:0]  src_q, src_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              blank_q, blank_d;
   logic              pulse_q, pulse_d;
   logic [SRC_W-1:0]  last_q, last_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;

   logic              tick;
   logic              grant;
   logic [SRC_W-1:0]  new_src;
   logic [SRC_W-1:0]  rr_idx;
   logic              any_valid, pin_ok, cur_valid, expire;
   logic [DATA_W-1:0] slice [SRC_N];

   ms_tick_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_ms_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (grant),
      .tick  (tick)
   );

   always_comb begin
      for (int unsigned i = 0; i < SRC_N; i++) begin
         slice[i] = src_data[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin: first valid source after last_q; wraps to last_q itself on the 4th probe.
   always_comb begin
      rr_idx = last_q;
      for (int unsigned k = SRC_N; k >= 1; k--) begin
         if (src_valid[last_q + SRC_W'(k)]) begin
            rr_idx = last_q + SRC_W'(k);
         end
      end
   end

   assign any_valid = |src_valid;
   assign pin_ok    = pin_en && src_valid[pin_sel];
   assign cur_valid = src_valid[src_q];
   assign expire    = tick && (dwell_q == DWELL_LAST);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      data_d  = data_q;
      blank_d = blank_q;
      pulse_d = 1'b0;
      last_d  = last_q;
      grant   = 1'b0;
      new_src = src_q;

      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant   = 1'b1;
               new_src = pin_ok ? pin_sel : rr_idx;
               pulse_d = 1'b1;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (pin_ok) begin
               if (pin_sel != src_q) begin
                  grant   = 1'b1;
                  new_src = pin_sel;
                  pulse_d = 1'b1;
               end else if (expire) begin
                  grant = 1'b1;  // pinned: restart dwell, no rotation
               end
            end else if (!cur_valid) begin
               // Drop takes precedence over a coinciding expiry.
               if (any_valid) begin
                  grant   = 1'b1;
                  new_src = rr_idx;
                  pulse_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (expire) begin
               grant   = 1'b1;
               new_src = rr_idx;
               pulse_d = (rr_idx != src_q);
            end
         end
      endcase

      if (state_d == SHOW) begin
         src_d   = new_src;
         data_d  = slice[new_src];
         blank_d = 1'b0;
         if (grant) begin
            last_d = new_src;
         end
      end else begin
         data_d  = '0;
         blank_d = 1'b1;
      end
   end

   always_comb begin
      dwell_d = dwell_q;
      if (grant) begin
         dwell_d = '0;
      end else if (tick) begin
         dwell_d = (dwell_q == DWELL_LAST) ? '0 : dwell_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         data_q  <= '0;
         blank_q <= 1'b1;
         pulse_q <= 1'b0;
         last_q  <= SRC_W'(SRC_N - 1);
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         data_q  <= data_d;
         blank_q <= blank_d;
         pulse_q <= pulse_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
      end
   end

   assign disp_data    = data_q;
   assign disp_src     = src_q;
   assign disp_blank   = blank_q;
   assign switch_pulse = pulse_q;

endmodule
